// File: rtl/fetch_inst_buf_if.sv
// Fetch-to-decode instruction buffer bus: push side, pop side, flush and occupancy.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready throttles fetch, out_ready throttles the buffer head.
interface fetch_inst_buf_if #(
  parameter int ADDR  = 32,
  parameter int INST  = 32,
  parameter int DEPTH = 8
);
  localparam int CNT = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [ADDR-1:0] in_pc;
  logic [INST-1:0] in_inst;
  logic            in_pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic [ADDR-1:0] out_pc;
  logic [INST-1:0] out_inst;
  logic            out_pred_taken;
  logic [CNT-1:0]  count;

  // Driver side: fetch/decode/redirect logic (or a testbench)
  modport master (
    output flush, in_valid, in_pc, in_inst, in_pred_taken, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_pred_taken, count
  );

  // Buffer side
  modport slave (
    input  flush, in_valid, in_pc, in_inst, in_pred_taken, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_pred_taken, count
  );
endinterface

// File: rtl/fetch_inst_buf.sv
// Circular instruction FIFO decoupling fetch from decode; flush empties it in one cycle.
// Latency: 1 cycle push-to-out_valid (0 cycles when empty with INST_BUF_BYPASS_EN defined).
// Backpressure: in_ready = !full && !flush, no combinational path from out_ready; out_ready ignored when empty.
module fetch_inst_buf #(
  parameter int ADDR  = 32,
  parameter int INST  = 32,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  fetch_inst_buf_if.slave   bus
);
  localparam int CNT = $clog2(DEPTH) + 1;
  localparam int PTR = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [INST-1:0] inst;
    logic            pred_taken;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT-1:0] count_q, count_d;

  logic   full, empty, push, pop;
  entry_t in_ent, head, out_ent;

  // Status, handshake decode and head presentation
  always_comb begin
    full   = (count_q == CNT'(DEPTH));
    empty  = (count_q == '0);
    in_ent = '{pc: bus.in_pc, inst: bus.in_inst, pred_taken: bus.in_pred_taken};
    head   = mem_q[rd_ptr_q];

    bus.in_ready  = !full && !bus.flush;
    bus.out_valid = !empty;
    // Stale array contents are masked so the head reads zero while empty
    out_ent       = empty ? '0 : head;
    pop           = !empty && bus.out_ready && !bus.flush;
    push          = bus.in_valid && bus.in_ready;

`ifdef INST_BUF_BYPASS_EN
    // Empty buffer forwards fetch straight to decode; a consumed entry is never stored
    if (empty && !bus.flush) begin
      bus.out_valid = bus.in_valid;
      out_ent       = in_ent;
      push          = bus.in_valid && bus.in_ready && !bus.out_ready;
    end
`endif

    bus.out_pc         = out_ent.pc;
    bus.out_inst       = out_ent.inst;
    bus.out_pred_taken = out_ent.pred_taken;
    bus.count          = count_q;
  end

  // Pointer and occupancy next state; flush overrides any push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR'(1);
      if (push && !pop)      count_d = count_q + CNT'(1);
      else if (pop && !push) count_d = count_q - CNT'(1);
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, intentionally left unreset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_ent;
  end
endmodule

// File: tb/tb_fetch_inst_buf.sv
// Directed self-checking bench for fetch_inst_buf.
// Latency: checks registered state 1 time unit after each rising edge.
// Backpressure: exercises full, empty, push-with-pop and flush cases.
module tb_fetch_inst_buf;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_inst_buf_if bus ();

  fetch_inst_buf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset             = 1'b1;
    bus.flush         = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_pc         = '0;
    bus.in_inst       = '0;
    bus.in_pred_taken = 1'b0;
    bus.out_ready     = 1'b0;
    #1;
    chk("rst_count",     64'(bus.count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_out_pc",    64'(bus.out_pc), 64'd0);
    chk("rst_out_inst",  64'(bus.out_inst), 64'd0);
    chk("rst_out_pt",    64'(bus.out_pred_taken), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc();

    // Single push, decode stalled
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h1000;
    bus.in_inst  = 32'h0000_0013;
    #1;
    chk("single_same_cycle_valid", 64'(bus.out_valid), 64'd0);
    cyc();
    bus.in_valid = 1'b0;
    chk("single_out_valid", 64'(bus.out_valid), 64'd1);
    chk("single_out_pc",    64'(bus.out_pc), 64'h1000);
    chk("single_out_inst",  64'(bus.out_inst), 64'h13);
    chk("single_out_pt",    64'(bus.out_pred_taken), 64'd0);
    chk("single_count",     64'(bus.count), 64'd1);

    // Flush back to empty with pointers at zero
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("flush1_count",     64'(bus.count), 64'd0);
    chk("flush1_out_valid", 64'(bus.out_valid), 64'd0);

    // Fill all 8 entries
    for (int i = 0; i < 8; i++) begin
      bus.in_valid      = 1'b1;
      bus.in_pc         = 32'h2000 + 32'(4 * i);
      bus.in_inst       = 32'hA000_0000 + 32'(i);
      bus.in_pred_taken = i[0];
      #1;
      chk($sformatf("fill_in_ready_%0d", i), 64'(bus.in_ready), 64'd1);
      cyc();
    end
    chk("full_count",    64'(bus.count), 64'd8);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_out_pc",   64'(bus.out_pc), 64'h2000);

    // Ninth offer held while full
    bus.in_pc         = 32'h2020;
    bus.in_inst       = 32'hA000_0008;
    bus.in_pred_taken = 1'b0;
    #1;
    chk("ninth_in_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    chk("ninth_count", 64'(bus.count), 64'd8);

    // Pop from full with offer still present: no same-cycle refill
    bus.out_ready = 1'b1;
    #1;
    chk("fullpop_in_ready", 64'(bus.in_ready), 64'd0);
    chk("fullpop_out_pc",   64'(bus.out_pc), 64'h2000);
    chk("fullpop_out_inst", 64'(bus.out_inst), 64'hA000_0000);
    cyc();
    bus.out_ready = 1'b0;
    chk("afterpop_count",    64'(bus.count), 64'd7);
    chk("afterpop_in_ready", 64'(bus.in_ready), 64'd1);
    chk("afterpop_out_pc",   64'(bus.out_pc), 64'h2004);
    chk("afterpop_out_pt",   64'(bus.out_pred_taken), 64'd1);
    cyc();
    bus.in_valid = 1'b0;
    chk("wrap_count",    64'(bus.count), 64'd8);
    chk("wrap_in_ready", 64'(bus.in_ready), 64'd0);

    // Drain; last entry is the one written after pointer wrap
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("drain_pc_%0d", i), 64'(bus.out_pc), 64'h2004 + 64'(4 * i));
      cyc();
    end
    bus.out_ready = 1'b0;
    chk("drain_count",     64'(bus.count), 64'd0);
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);

    // Streaming: one entry in flight, push and pop every cycle
    bus.in_valid      = 1'b1;
    bus.in_pc         = 32'h4000;
    bus.in_inst       = 32'h4000;
    bus.in_pred_taken = 1'b0;
    cyc();
    bus.out_ready = 1'b1;
    for (int k = 1; k < 20; k++) begin
      bus.in_pc   = 32'h4000 + 32'(4 * k);
      bus.in_inst = 32'h4000 + 32'(4 * k);
      #1;
      chk($sformatf("stream_pc_%0d", k), 64'(bus.out_pc), 64'h4000 + 64'(4 * (k - 1)));
      chk($sformatf("stream_count_%0d", k), 64'(bus.count), 64'd1);
      cyc();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("stream_last_pc", 64'(bus.out_pc), 64'h404C);
    cyc();
    bus.out_ready = 1'b0;
    chk("stream_end_count", 64'(bus.count), 64'd0);

    // Load 5, then flush while pushing and popping
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pc    = 32'h5000 + 32'(4 * i);
      bus.in_inst  = 32'h5000 + 32'(4 * i);
      cyc();
    end
    chk("load5_count", 64'(bus.count), 64'd5);
    bus.flush     = 1'b1;
    bus.in_pc     = 32'h6000;
    bus.in_inst   = 32'h6000;
    bus.out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    chk("flush_count",     64'(bus.count), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    cyc();
    chk("flush_held_count", 64'(bus.count), 64'd0);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("postflush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("postflush_out_pc",    64'(bus.out_pc), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h7000;
    bus.in_inst  = 32'h7000;
    cyc();
    bus.in_valid = 1'b0;
    chk("postflush_push_pc",    64'(bus.out_pc), 64'h7000);
    chk("postflush_push_count", 64'(bus.count), 64'd1);

    // Asynchronous reset mid-operation
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_count",     64'(bus.count), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("midrst_out_pc",    64'(bus.out_pc), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc();

`ifdef INST_BUF_BYPASS_EN
    // Zero-latency forward through an empty buffer
    bus.in_valid      = 1'b1;
    bus.in_pc         = 32'h3000;
    bus.in_inst       = 32'h3000;
    bus.in_pred_taken = 1'b1;
    bus.out_ready     = 1'b1;
    #1;
    chk("bypass_out_valid", 64'(bus.out_valid), 64'd1);
    chk("bypass_out_pc",    64'(bus.out_pc), 64'h3000);
    chk("bypass_out_pt",    64'(bus.out_pred_taken), 64'd1);
    cyc();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("bypass_count", 64'(bus.count), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
